// File: rtl/enc_pkg.sv
// Package: enc_pkg
// Shared definitions for the prio_encoder_rr arbiter/encoder stage.
//   mode_t     : 2-bit encoder mode selector
//   MODE_HI    : highest set index wins
//   MODE_LO    : lowest set index wins
//   MODE_RR    : round-robin, scan upward from the rotating pointer
//   MODE_RSV   : reserved, behaves exactly like MODE_HI
package enc_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HI  = 2'd0;
  localparam mode_t MODE_LO  = 2'd1;
  localparam mode_t MODE_RR  = 2'd2;
  localparam mode_t MODE_RSV = 2'd3;

endpackage

// File: rtl/prio_scan.sv
// Module: prio_scan
// Combinational circular priority scan over an N-bit vector.
//   x     in  N  vector to scan
//   start in  W  index examined first
//   dir   in  1  1 = scan upward (start, start+1, ...), 0 = scan downward;
//                 both directions wrap modulo N
//   idx   out W  first set index met by the scan (0 when none)
//   found out 1  at least one bit of x is set
module prio_scan #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] x,
  input  logic [W-1:0] start,
  input  logic         dir,
  output logic [W-1:0] idx,
  output logic         found
);

  int p;

  // Walk the scan order back to front so the earliest position in scan
  // order is the last one written and therefore wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    p     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dir) p = (int'(start) + i) % N;
      else     p = (int'(start) - i + N) % N;
      if (x[p]) begin
        idx   = W'(p);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Module: prio_encoder_rr
// One-entry registered priority encoder with highest / lowest / round-robin
// selection, one-hot grant and popcount of the captured request vector.
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous reset, active low
//   en         in   1    encoder enable, sampled on capture
//   mode       in   2    0 highest, 1 lowest, 2 round-robin, 3 as 0
//   x          in   N    request vector, sampled on capture
//   in_valid   in   1    request valid
//   in_ready   out  1    stage can accept a request this cycle
//   y          out  W    winning index
//   tur        out  1    a request bit was set and en was 1
//   grant      out  N    one-hot of the winner, zero when tur=0
//   cnt        out  W+1  popcount of captured x (0 when en=0)
//   out_valid  out  1    result registers hold an unconsumed result
//   out_ready  in   1    consumer accepts the result
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and the producer holds its data
// stable while valid is high and ready is low. On the input side the stage
// is ready when empty or when its current result retires in the same cycle.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] x,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         tur,
  output logic [N-1:0] grant,
  output logic [W:0]   cnt,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [W-1:0] scan_start;
  logic         scan_dir;
  logic [W-1:0] scan_idx;
  logic         scan_found;
  logic [W:0]   pop;
  logic         capture;
  logic         hit;
  mode_t        mode_sel;

  assign mode_sel = mode_t'(mode);
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;
  assign hit      = en && scan_found;

  // Lowest-wins is an upward scan from 0, highest-wins a downward scan from
  // N-1, round-robin an upward scan from the pointer.
  always_comb begin
    scan_start = W'(N - 1);
    scan_dir   = 1'b0;
    case (mode_sel)
      MODE_LO: begin
        scan_start = '0;
        scan_dir   = 1'b1;
      end
      MODE_RR: begin
        scan_start = ptr;
        scan_dir   = 1'b1;
      end
      default: begin
        scan_start = W'(N - 1);
        scan_dir   = 1'b0;
      end
    endcase
  end

  prio_scan #(.N(N), .W(W)) u_scan (
    .x     (x),
    .start (scan_start),
    .dir   (scan_dir),
    .idx   (scan_idx),
    .found (scan_found)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + {{W{1'b0}}, x[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      tur       <= 1'b0;
      grant     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      tur       <= hit;
      y         <= hit ? scan_idx : '0;
      grant     <= hit ? ({{(N-1){1'b0}}, 1'b1} << scan_idx) : '0;
      cnt       <= en ? pop : '0;
      // Pointer advances past the winner only for round-robin grants.
      if (hit && (mode_sel == MODE_RR)) begin
        ptr <= (scan_idx == W'(N - 1)) ? '0 : scan_idx + W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: an N=8 and an N=5 instance share clock,
// reset and handshake/control inputs, each with its own request vector.
module tb_prio_encoder_rr;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // shared inputs
  logic       en;
  logic [1:0] mode;
  logic       in_valid;
  logic       out_ready;

  // N=8 instance
  logic [7:0] x;
  logic       in_ready;
  logic [2:0] y;
  logic       tur;
  logic [7:0] grant;
  logic [3:0] cnt;
  logic       out_valid;

  // N=5 instance
  logic [4:0] x5;
  logic       in_ready5;
  logic [2:0] y5;
  logic       tur5;
  logic [4:0] grant5;
  logic [3:0] cnt5;
  logic       out_valid5;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .tur(tur),
    .grant(grant), .cnt(cnt), .out_valid(out_valid), .out_ready(out_ready)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .x(x5),
    .in_valid(in_valid), .in_ready(in_ready5), .y(y5), .tur(tur5),
    .grant(grant5), .cnt(cnt5), .out_valid(out_valid5), .out_ready(out_ready)
  );

  int tests = 0;
  int fails = 0;

  // reference model state, index 0 = N=8, index 1 = N=5
  int          m_y[2];
  bit          m_tur[2];
  logic [63:0] m_grant[2];
  int          m_cnt[2];
  bit          m_ov[2];
  int          m_ptr[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 0; m_tur[k] = 0; m_grant[k] = '0;
      m_cnt[k] = 0; m_ov[k] = 0; m_ptr[k] = 0;
    end
  endtask

  // One rising edge of the behavioural stage for instance k of width n.
  task automatic model_edge(input int k, input int n, input logic [63:0] xv);
    bit rdy;
    int win;
    rdy = !m_ov[k] || out_ready;
    win = -1;
    if (in_valid && rdy) begin
      if (en) begin
        if (mode == 2'd2) begin
          for (int s = 0; s < n; s++) begin
            if (win < 0 && xv[(m_ptr[k] + s) % n]) win = (m_ptr[k] + s) % n;
          end
        end else if (mode == 2'd1) begin
          for (int j = n - 1; j >= 0; j--) if (xv[j]) win = j;
        end else begin
          for (int j = 0; j < n; j++) if (xv[j]) win = j;
        end
      end
      m_ov[k]    = 1;
      m_tur[k]   = (win >= 0);
      m_y[k]     = (win >= 0) ? win : 0;
      m_grant[k] = (win >= 0) ? (64'd1 << win) : 64'd0;
      m_cnt[k]   = en ? $countones(xv) : 0;
      if (mode == 2'd2 && win >= 0) m_ptr[k] = (win == n - 1) ? 0 : win + 1;
    end else if (out_ready) begin
      m_ov[k] = 0;
    end
  endtask

  task automatic check_all();
    chk("n8.in_ready",  64'(in_ready),  64'(!m_ov[0] || out_ready));
    chk("n8.out_valid", 64'(out_valid), 64'(m_ov[0]));
    chk("n8.y",         64'(y),         64'(m_y[0]));
    chk("n8.tur",       64'(tur),       64'(m_tur[0]));
    chk("n8.grant",     64'(grant),     m_grant[0]);
    chk("n8.cnt",       64'(cnt),       64'(m_cnt[0]));
    chk("n5.in_ready",  64'(in_ready5), 64'(!m_ov[1] || out_ready));
    chk("n5.out_valid", 64'(out_valid5),64'(m_ov[1]));
    chk("n5.y",         64'(y5),        64'(m_y[1]));
    chk("n5.tur",       64'(tur5),      64'(m_tur[1]));
    chk("n5.grant",     64'(grant5),    m_grant[1]);
    chk("n5.cnt",       64'(cnt5),      64'(m_cnt[1]));
  endtask

  // driver: one clock with model update and full output check
  task automatic step();
    @(posedge clk);
    model_edge(0, 8, 64'(x));
    model_edge(1, 5, 64'(x5));
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; x = '0; x5 = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // fixed-priority modes
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    mode = 2'd0; x = 8'b0010_0110; x5 = 5'b00110;
    step();
    chk("t2.y", 64'(y), 64'd5);
    chk("t2.grant", 64'(grant), 64'h20);
    chk("t2.cnt", 64'(cnt), 64'd3);
    chk("t2.tur", 64'(tur), 64'd1);
    mode = 2'd1;
    step();
    chk("t3.y", 64'(y), 64'd1);
    chk("t3.grant", 64'(grant), 64'h02);
    en = 1'b0;
    step();
    chk("t3.en0_tur", 64'(tur), 64'd0);
    chk("t3.en0_ov", 64'(out_valid), 64'd1);

    // asynchronous reset with a result pending
    en = 1'b1; mode = 2'd3; x = 8'h80; x5 = 5'b10001;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t1.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // round-robin rotation, wrap on both widths
    mode = 2'd2; x = 8'hFF; x5 = 5'b01000;
    step();
    chk("t4.y0", 64'(y), 64'd0);
    chk("t6.y3", 64'(y5), 64'd3);
    x5 = 5'b00011;
    step();
    chk("t4.y1", 64'(y), 64'd1);
    chk("t6.wrap", 64'(y5), 64'd0);
    step();
    chk("t4.y2", 64'(y), 64'd2);
    chk("t6.ptr1", 64'(y5), 64'd1);
    x5 = 5'($urandom);
    step();
    chk("t4.y3", 64'(y), 64'd3);
    x = 8'h01;
    step();
    chk("t4.wrap", 64'(y), 64'd0);
    x = 8'h03;
    step();
    chk("t4.ptr1", 64'(y), 64'd1);

    // backpressure then simultaneous retire + capture
    mode = 2'd0; x = 8'h10;
    step();
    out_ready = 1'b0; x = 8'h04;
    step();
    chk("t5.in_ready", 64'(in_ready), 64'd0);
    chk("t5.hold", 64'(y), 64'd4);
    x = 8'h02;
    step();
    chk("t5.hold2", 64'(y), 64'd4);
    out_ready = 1'b1; mode = 2'd1; x = 8'h08;
    #1;
    chk("t5.ready_back", 64'(in_ready), 64'd1);
    step();
    chk("t5.next", 64'(y), 64'd3);
    chk("t5.ov", 64'(out_valid), 64'd1);

    // randomized traffic
    repeat (300) begin
      mode      = 2'($urandom_range(0, 3));
      en        = ($urandom_range(0, 7) != 0);
      x         = 8'($urandom);
      if ($urandom_range(0, 2) == 0) x = x & 8'($urandom);
      if ($urandom_range(0, 9) == 0) x = '0;
      x5        = 5'($urandom);
      if ($urandom_range(0, 9) == 0) x5 = '0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
